// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_pkg
// Description : Shared constants and helpers for the register pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_pkg;

    localparam int REG_PIPE_DEPTH_MIN = 1;
    localparam int REG_PIPE_DEPTH_MAX = 16;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : reg_pipe_stage
// Description : One enable-gated pipeline stage (data + valid) with sync
//               reset to RST_VAL and a flush that clears valid only.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_pipe_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_dn_ready,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    // An empty stage always accepts, which is what lets bubbles collapse.
    assign o_ready = ~r_valid | i_dn_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= RST_VAL;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/reg_pipe_rst_sync.sv
`default_nettype none
// ============================================================================
// Module      : reg_pipe_rst_sync
// Description : DEPTH-stage valid/ready register pipeline, synchronous reset.
//               Define REG_PIPE_CNT_EN to add the o_cnt occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_pipe_rst_sync
    import reg_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 2,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data
`ifdef REG_PIPE_CNT_EN
    ,
    output logic [cnt_width(DEPTH)-1:0] o_cnt
`endif
);

    generate
        if (DEPTH < REG_PIPE_DEPTH_MIN || DEPTH > REG_PIPE_DEPTH_MAX) begin : g_depth_check
            $error("reg_pipe_rst_sync: DEPTH must be within 1..16");
        end
    endgenerate

    logic [DEPTH:0]        w_ready;
    logic [DEPTH-1:0]      w_valid;
    logic [DEPTH-1:0]      w_up_valid;
    logic [DATA_WIDTH-1:0] w_data    [DEPTH];
    logic [DATA_WIDTH-1:0] w_up_data [DEPTH];

    assign w_ready[DEPTH] = i_ready;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_up_valid[k] = i_valid;
                assign w_up_data[k]  = i_data;
            end else begin : g_body
                assign w_up_valid[k] = w_valid[k-1];
                assign w_up_data[k]  = w_data[k-1];
            end

            reg_pipe_stage #(
                .DATA_WIDTH (DATA_WIDTH),
                .RST_VAL    (RST_VAL)
            ) u_stage (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_flush    (i_flush),
                .i_dn_ready (w_ready[k+1]),
                .i_valid    (w_up_valid[k]),
                .i_data     (w_up_data[k]),
                .o_ready    (w_ready[k]),
                .o_valid    (w_valid[k]),
                .o_data     (w_data[k])
            );
        end
    endgenerate

    // Input is refused during a flush so nothing slips in behind the clear.
    assign o_ready = w_ready[0] & ~i_flush;
    assign o_valid = w_valid[DEPTH-1];
    assign o_data  = w_data[DEPTH-1];

`ifdef REG_PIPE_CNT_EN
    localparam int c_cnt_w = cnt_width(DEPTH);

    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [c_cnt_w-1:0] r_cnt;

    assign w_in_xfer  = i_valid & o_ready;
    assign w_out_xfer = o_valid & i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_cnt <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_cnt <= r_cnt - c_cnt_w'(1);
        end
    end

    assign o_cnt = r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_pipe_rst_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_pipe_rst_sync
// Description : Directed + random bench for reg_pipe_rst_sync (DEPTH=3)
//               against a queue-based item model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_pipe_rst_sync;

    localparam int          c_dw    = 32;
    localparam int          c_depth = 3;
    localparam logic [31:0] c_rst   = 32'h0;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0, i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
    logic [31:0] i_data = '0;
    logic        o_ready, o_valid;
    logic [31:0] o_data;
`ifdef REG_PIPE_CNT_EN
    logic [1:0]  o_cnt;
`endif

    always #5 clk = ~clk;

    reg_pipe_rst_sync #(
        .DATA_WIDTH (c_dw),
        .DEPTH      (c_depth),
        .RST_VAL    (c_rst)
    ) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data)
`ifdef REG_PIPE_CNT_EN
        ,
        .o_cnt   (o_cnt)
`endif
    );

    typedef struct {
        logic [31:0] data;
        int          pos;
    } item_t;

    item_t q[$];
    int    n_cmp = 0;
    int    n_mis = 0;
    bit    model_live = 0;
    bit    just_reset = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Items are a FIFO tagged with their stage position; each cycle an item
    // moves forward one position if the next position is free after the move.
    task automatic step(input logic rst_v, input logic flush_v, input logic valid_v,
                        input logic [31:0] data_v, input logic ready_v);
        bit    exp_valid, exp_ready, do_in;
        item_t it;
        int    lim;
        i_rst   = rst_v;
        i_flush = flush_v;
        i_valid = valid_v;
        i_data  = data_v;
        i_ready = ready_v;
        #4;
        exp_valid = (q.size() > 0) && (q[0].pos == c_depth - 1);
        exp_ready = !flush_v && ((q.size() < c_depth) || ready_v);
        if (model_live) begin
            check("o_valid", {31'b0, o_valid}, {31'b0, exp_valid});
            check("o_ready", {31'b0, o_ready}, {31'b0, exp_ready});
            if (exp_valid) check("o_data", o_data, q[0].data);
            if (just_reset) check("o_data_rst", o_data, c_rst);
`ifdef REG_PIPE_CNT_EN
            check("o_cnt", {30'b0, o_cnt}, q.size());
`endif
        end
        @(posedge clk);
        if (rst_v) begin
            q.delete();
            model_live = 1;
        end else if (flush_v) begin
            q.delete();
        end else begin
            do_in = valid_v && exp_ready;
            if (exp_valid && ready_v) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) begin
                lim = (i == 0) ? c_depth - 1 : q[i-1].pos - 1;
                it  = q[i];
                if (it.pos < lim) it.pos++;
                q[i] = it;
            end
            if (do_in) begin
                it.data = data_v;
                it.pos  = 0;
                q.push_back(it);
            end
        end
        just_reset = rst_v;
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, $urandom, rdy);
    endtask

    initial begin
        // Reset with junk on the input
        step(1, 0, 1, 32'hFFFF0000, 0);
        step(1, 0, 1, 32'hFFFF0000, 0);
        idle(1, 0);

        // Streaming 1..5
        for (int v = 1; v <= 5; v++) step(0, 0, 1, v, 1);
        idle(5, 1);

        // Backpressure: A,B,C fill, D refused until i_ready rises
        step(0, 0, 1, 32'hA, 0);
        step(0, 0, 1, 32'hB, 0);
        step(0, 0, 1, 32'hC, 0);
        step(0, 0, 1, 32'hD, 0);
        step(0, 0, 1, 32'hD, 0);
        step(0, 0, 1, 32'hD, 1);
        idle(5, 1);

        // Full, then simultaneous in/out with E
        step(0, 0, 1, 32'h11, 0);
        step(0, 0, 1, 32'h12, 0);
        step(0, 0, 1, 32'h13, 0);
        step(0, 0, 1, 32'hE, 1);
        idle(5, 1);

        // Flush with two items in flight and i_valid asserted
        step(0, 0, 1, 32'h21, 1);
        step(0, 0, 1, 32'h22, 1);
        step(0, 1, 1, 32'h77, 0);
        idle(4, 1);

        // Reset mid-operation from full
        step(0, 0, 1, 32'h31, 0);
        step(0, 0, 1, 32'h32, 0);
        step(0, 0, 1, 32'h33, 0);
        step(1, 0, 1, 32'h34, 1);
        step(0, 0, 1, 32'h55, 1);
        idle(4, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 6));
        end
        idle(6, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
